register_file_param: RTL and testbench

//  Parametrised CPU register file: 2 read ports, 1 read/write port, sticky FLAG register with
//  ATC (acknowledge-and-clear), memory-mapped I/O registers (DINP/GOUT/DOUT), synchronised DINP.

---
 rtl/register_file_param_if.sv | 50 +++++
 rtl/register_file_param.sv | 241 ++++++++++++++++++++++++
 tb/tb_register_file_param.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_param_if
//  Purpose  : Bus bundle between the CPU core and register_file_param.
//             Carries the read/write ports, flag/ATC controls, the
//             memory-mapped I/O views and the clear-sweep handshake.
//  Modports : master - CPU / stimulus side (drives requests)
//             slave  - register file side (drives read data and status)
//  Revision : 1.0 - initial release
// ============================================================================
interface register_file_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int NFLAGS = 7,
    parameter int ATC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
);
    logic                enable;
    logic [ADDR_W-1:0]   a_addr;
    logic [DATA_W-1:0]   a_data_out;
    logic [ADDR_W-1:0]   b_addr;
    logic [DATA_W-1:0]   b_data_in;
    logic                b_wr_enable;
    logic [DATA_W-1:0]   b_data_out;
    logic [NFLAGS-1:0]   flag_inputs;
    logic                is_atc;
    logic [ATC_W-1:0]    atc_bit;
    logic                atc_out;
    logic [DATA_W-1:0]   reg_din;
    logic [DATA_W-1:0]   reg_gout;
    logic [DATA_W-1:0]   reg_dout;
    logic [DATA_W-1:0]   reg_flag;
    logic                gout_dval;
    logic                clr_req;
    logic                busy;

    modport master (
        output enable, a_addr, b_addr, b_data_in, b_wr_enable,
               flag_inputs, is_atc, atc_bit, reg_din, clr_req,
        input  a_data_out, b_data_out, atc_out, reg_gout, reg_dout,
               reg_flag, gout_dval, busy
    );

    modport slave (
        input  enable, a_addr, b_addr, b_data_in, b_wr_enable,
               flag_inputs, is_atc, atc_bit, reg_din, clr_req,
        output a_data_out, b_data_out, atc_out, reg_gout, reg_dout,
               reg_flag, gout_dval, busy
    );
endinterface
`default_nettype wire

// File: rtl/register_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_param
//  Purpose  : Parametrised CPU register file with two read ports (a, b), one
//             write port (b), a sticky FLAG register with acknowledge-and-
//             clear, memory-mapped DINP/GOUT/DOUT registers, a synchronised
//             external data input and a hardware clear sweep.
//  Ports    : clk     - clock, rising edge
//             resetn  - asynchronous reset, active low
//             rf      - register_file_param_if.slave bundle:
//                       a_addr/a_data_out, b_addr/b_data_in/b_wr_enable/
//                       b_data_out, enable, flag_inputs, is_atc/atc_bit/
//                       atc_out, reg_din, reg_gout/reg_dout/reg_flag,
//                       gout_dval, clr_req/busy
//  Revision : 1.0 - initial release
// ============================================================================
module register_file_param #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int NFLAGS      = 7,
    parameter int DINP_ADDR   = 28,
    parameter int GOUT_ADDR   = 29,
    parameter int DOUT_ADDR   = 30,
    parameter int FLAG_ADDR   = 31,
    parameter int SYNC_STAGES = 2,
    parameter int REG_READ    = 0
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    register_file_param_if.slave rf
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The sweep visits every address once; the last visit (DEPTH-1) returns
    // to IDLE so busy stays high for exactly DEPTH cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rf.clr_req) begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                w_busy    = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_last_addr) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Common controls
    // ------------------------------------------------------------------
    logic w_wr;
    logic w_atc_clr;

    assign w_wr      = rf.enable & rf.b_wr_enable & ~w_busy;
    assign w_atc_clr = rf.enable & rf.is_atc;

    // ------------------------------------------------------------------
    // reg_din synchroniser
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_din_sync;

    generate
        if (SYNC_STAGES == 0) begin : g_sync_none
            assign w_din_sync = rf.reg_din;
        end else begin : g_sync
            logic [DATA_W-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= '0;
                    end
                end else begin
                    r_sync[0] <= rf.reg_din;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= r_sync[s-1];
                    end
                end
            end

            assign w_din_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Flag next-state: a set pulse beats an ATC clear of the same bit, and
    // set pulses are honoured even when the CPU is stalled or sweeping.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_mem [DEPTH];
    logic [DATA_W-1:0] w_flag_cur;
    logic [DATA_W-1:0] w_flag_nxt;

    assign w_flag_cur = w_mem[FLAG_ADDR];

    always_comb begin
        w_flag_nxt = '0;
        for (int b = 0; b < NFLAGS; b++) begin
            if (rf.flag_inputs[b]) begin
                w_flag_nxt[b] = 1'b1;
            end else if (w_atc_clr && (int'(rf.atc_bit) == b)) begin
                w_flag_nxt[b] = 1'b0;
            end else begin
                w_flag_nxt[b] = w_flag_cur[b];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register array: each entry is its own flop group so the special
    // addresses (DINP, FLAG) get dedicated update rules and never see
    // port-b writes or sweep clears.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic [DATA_W-1:0] r_q;

            if (gi == DINP_ADDR) begin : g_dinp
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        r_q <= '0;
                    end else begin
                        r_q <= w_din_sync;
                    end
                end
            end else if (gi == FLAG_ADDR) begin : g_flag
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        r_q <= '0;
                    end else begin
                        r_q <= w_flag_nxt;
                    end
                end
            end else begin : g_gp
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        r_q <= '0;
                    end else if (w_busy && (r_cnt == ADDR_W'(gi))) begin
                        r_q <= '0;
                    end else if (w_wr && (rf.b_addr == ADDR_W'(gi))) begin
                        r_q <= rf.b_data_in;
                    end
                end
            end

            assign w_mem[gi] = r_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    generate
        if (REG_READ != 0) begin : g_rd_reg
            logic [DATA_W-1:0] r_a_q;
            logic [DATA_W-1:0] r_b_q;

            // Sampled from the pre-edge array, so a same-cycle write to the
            // same address shows the old contents.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_a_q <= '0;
                    r_b_q <= '0;
                end else begin
                    r_a_q <= w_mem[rf.a_addr];
                    r_b_q <= w_mem[rf.b_addr];
                end
            end

            assign rf.a_data_out = r_a_q;
            assign rf.b_data_out = r_b_q;
        end else begin : g_rd_comb
            assign rf.a_data_out = w_mem[rf.a_addr];
            assign rf.b_data_out = w_mem[rf.b_addr];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Status and memory-mapped outputs
    // ------------------------------------------------------------------
    logic r_gout_dval;
    logic w_atc_in_range;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gout_dval <= 1'b0;
        end else begin
            r_gout_dval <= 1'b1;
        end
    end

    assign w_atc_in_range = (int'(rf.atc_bit) < NFLAGS);

    assign rf.atc_out   = rf.is_atc & w_atc_in_range & w_flag_cur[rf.atc_bit];
    assign rf.reg_gout  = w_mem[GOUT_ADDR];
    assign rf.reg_dout  = w_mem[DOUT_ADDR];
    assign rf.reg_flag  = w_flag_cur;
    assign rf.gout_dval = r_gout_dval;
    assign rf.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_register_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_param
//  Purpose  : Self-checking bench for register_file_param. Two instances
//             share all inputs: dut0 with combinational reads, dut1 with
//             registered reads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_param;

    logic clk;
    logic resetn;

    register_file_param_if #(.DATA_W(8), .ADDR_W(5), .NFLAGS(7)) rf0 ();
    register_file_param_if #(.DATA_W(8), .ADDR_W(5), .NFLAGS(7)) rf1 ();

    register_file_param #(.REG_READ(0)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .rf     (rf0.slave)
    );

    register_file_param #(.REG_READ(1)) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .rf     (rf1.slave)
    );

    assign rf1.enable      = rf0.enable;
    assign rf1.a_addr      = rf0.a_addr;
    assign rf1.b_addr      = rf0.b_addr;
    assign rf1.b_data_in   = rf0.b_data_in;
    assign rf1.b_wr_enable = rf0.b_wr_enable;
    assign rf1.flag_inputs = rf0.flag_inputs;
    assign rf1.is_atc      = rf0.is_atc;
    assign rf1.atc_bit     = rf0.atc_bit;
    assign rf1.reg_din     = rf0.reg_din;
    assign rf1.clr_req     = rf0.clr_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic       we;
        logic [4:0] baddr;
        logic [7:0] bdata;
        logic [4:0] aaddr;
        logic [6:0] fin;
        logic       atc;
        logic [2:0] abit;
        logic [7:0] exp_a;     // port a contents before the edge
        logic       exp_atc;   // atc_out before the edge
        logic [7:0] exp_flag;  // reg_flag after the edge
        logic [7:0] exp_gout;  // reg_gout after the edge
        logic [7:0] exp_dout;  // reg_dout after the edge
    } vec_t;

    function automatic vec_t mk(
        input logic en, input logic we, input logic [4:0] baddr, input logic [7:0] bdata,
        input logic [4:0] aaddr, input logic [6:0] fin, input logic atc, input logic [2:0] abit,
        input logic [7:0] exp_a, input logic exp_atc, input logic [7:0] exp_flag,
        input logic [7:0] exp_gout, input logic [7:0] exp_dout);
        vec_t v;
        v.en = en; v.we = we; v.baddr = baddr; v.bdata = bdata; v.aaddr = aaddr;
        v.fin = fin; v.atc = atc; v.abit = abit; v.exp_a = exp_a; v.exp_atc = exp_atc;
        v.exp_flag = exp_flag; v.exp_gout = exp_gout; v.exp_dout = exp_dout;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        int nbusy;

        //           en we  baddr  bdata  aaddr  fin      atc abit exp_a  atc  flag   gout   dout
        vecs[0]  = mk(1, 1, 5'd3,  8'hA5, 5'd3,  7'h00,   0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        vecs[1]  = mk(1, 0, 5'd0,  8'h00, 5'd3,  7'h00,   0, 3'd0, 8'hA5, 0, 8'h00, 8'h00, 8'h00);
        vecs[2]  = mk(1, 1, 5'd31, 8'hFF, 5'd31, 7'h00,   0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        vecs[3]  = mk(1, 0, 5'd0,  8'h00, 5'd31, 7'h04,   0, 3'd0, 8'h00, 0, 8'h04, 8'h00, 8'h00);
        vecs[4]  = mk(1, 0, 5'd0,  8'h00, 5'd31, 7'h00,   1, 3'd2, 8'h04, 1, 8'h00, 8'h00, 8'h00);
        vecs[5]  = mk(1, 0, 5'd0,  8'h00, 5'd31, 7'h04,   0, 3'd0, 8'h00, 0, 8'h04, 8'h00, 8'h00);
        vecs[6]  = mk(1, 0, 5'd0,  8'h00, 5'd31, 7'h04,   1, 3'd2, 8'h04, 1, 8'h04, 8'h00, 8'h00);
        vecs[7]  = mk(0, 0, 5'd0,  8'h00, 5'd31, 7'h00,   1, 3'd2, 8'h04, 1, 8'h04, 8'h00, 8'h00);
        vecs[8]  = mk(0, 1, 5'd5,  8'h77, 5'd5,  7'h00,   0, 3'd0, 8'h00, 0, 8'h04, 8'h00, 8'h00);
        vecs[9]  = mk(1, 0, 5'd0,  8'h00, 5'd5,  7'h00,   0, 3'd0, 8'h00, 0, 8'h04, 8'h00, 8'h00);
        vecs[10] = mk(1, 0, 5'd0,  8'h00, 5'd3,  7'h40,   1, 3'd7, 8'hA5, 0, 8'h44, 8'h00, 8'h00);
        vecs[11] = mk(1, 0, 5'd0,  8'h00, 5'd31, 7'h00,   1, 3'd6, 8'h44, 1, 8'h04, 8'h00, 8'h00);
        vecs[12] = mk(1, 1, 5'd28, 8'h55, 5'd28, 7'h00,   0, 3'd0, 8'h00, 0, 8'h04, 8'h00, 8'h00);
        vecs[13] = mk(1, 0, 5'd0,  8'h00, 5'd28, 7'h00,   0, 3'd0, 8'h00, 0, 8'h04, 8'h00, 8'h00);
        vecs[14] = mk(1, 1, 5'd29, 8'h12, 5'd29, 7'h00,   0, 3'd0, 8'h00, 0, 8'h04, 8'h12, 8'h00);
        vecs[15] = mk(1, 1, 5'd30, 8'h34, 5'd29, 7'h00,   0, 3'd0, 8'h12, 0, 8'h04, 8'h12, 8'h34);

        // ---------------- reset ----------------
        resetn          = 1'b0;
        rf0.enable      = 1'b0;
        rf0.a_addr      = '0;
        rf0.b_addr      = '0;
        rf0.b_data_in   = '0;
        rf0.b_wr_enable = 1'b0;
        rf0.flag_inputs = '0;
        rf0.is_atc      = 1'b0;
        rf0.atc_bit     = '0;
        rf0.reg_din     = '0;
        rf0.clr_req     = 1'b0;
        tick();
        tick();
        check("rst busy",      32'(rf0.busy),       32'h0);
        check("rst gout_dval", 32'(rf0.gout_dval),  32'h0);
        check("rst flag",      32'(rf0.reg_flag),   32'h0);
        check("rst a_data",    32'(rf0.a_data_out), 32'h0);
        check("rst a1_data",   32'(rf1.a_data_out), 32'h0);
        resetn = 1'b1;
        #1;
        check("rel gout_dval pre-edge", 32'(rf0.gout_dval), 32'h0);
        tick();
        check("rel gout_dval", 32'(rf0.gout_dval), 32'h1);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 16; i++) begin
            rf0.enable      = vecs[i].en;
            rf0.b_wr_enable = vecs[i].we;
            rf0.b_addr      = vecs[i].baddr;
            rf0.b_data_in   = vecs[i].bdata;
            rf0.a_addr      = vecs[i].aaddr;
            rf0.flag_inputs = vecs[i].fin;
            rf0.is_atc      = vecs[i].atc;
            rf0.atc_bit     = vecs[i].abit;
            #1;
            check($sformatf("v%0d a_data", i),  32'(rf0.a_data_out), 32'(vecs[i].exp_a));
            check($sformatf("v%0d atc_out", i), 32'(rf0.atc_out),    32'(vecs[i].exp_atc));
            tick();
            check($sformatf("v%0d a_data_reg", i), 32'(rf1.a_data_out), 32'(vecs[i].exp_a));
            check($sformatf("v%0d flag", i),       32'(rf0.reg_flag),   32'(vecs[i].exp_flag));
            check($sformatf("v%0d gout", i),       32'(rf0.reg_gout),   32'(vecs[i].exp_gout));
            check($sformatf("v%0d dout", i),       32'(rf0.reg_dout),   32'(vecs[i].exp_dout));
        end
        rf0.b_wr_enable = 1'b0;
        rf0.is_atc      = 1'b0;
        rf0.flag_inputs = '0;

        // ---------------- DINP synchroniser, enable low ----------------
        rf0.enable  = 1'b0;
        rf0.a_addr  = 5'd28;
        rf0.reg_din = 8'h3C;
        tick();
        check("dinp edge1", 32'(rf0.a_data_out), 32'h00);
        tick();
        check("dinp edge2", 32'(rf0.a_data_out), 32'h00);
        tick();
        check("dinp edge3", 32'(rf0.a_data_out), 32'h3C);

        // ---------------- clear sweep ----------------
        rf0.enable      = 1'b1;
        rf0.b_wr_enable = 1'b1;
        for (int i = 0; i < 31; i++) begin
            rf0.b_addr    = 5'(i);
            rf0.b_data_in = 8'(i + 1);
            tick();
        end
        rf0.b_wr_enable = 1'b0;
        rf0.flag_inputs = 7'h01;
        tick();
        rf0.flag_inputs = 7'h00;
        rf0.a_addr = 5'd30;
        #1;
        check("fill r30", 32'(rf0.a_data_out), 32'h1F);
        check("fill flag", 32'(rf0.reg_flag), 32'h05);

        rf0.clr_req = 1'b1;
        tick();
        rf0.clr_req = 1'b0;
        check("sweep start busy", 32'(rf0.busy), 32'h1);
        nbusy = 0;
        while (rf0.busy && nbusy < 100) begin
            nbusy++;
            if (nbusy == 3) begin
                rf0.b_addr      = 5'd0;
                rf0.b_data_in   = 8'hEE;
                rf0.b_wr_enable = 1'b1;
            end else begin
                rf0.b_wr_enable = 1'b0;
            end
            rf0.clr_req = (nbusy == 6);
            tick();
        end
        rf0.clr_req     = 1'b0;
        rf0.b_wr_enable = 1'b0;
        check("sweep busy cycles", 32'(nbusy), 32'd32);
        for (int i = 0; i < 32; i++) begin
            rf0.a_addr = 5'(i);
            #1;
            check($sformatf("swept r%0d", i), 32'(rf0.a_data_out),
                  (i == 28) ? 32'h3C : ((i == 31) ? 32'h05 : 32'h00));
        end
        check("swept gout", 32'(rf0.reg_gout), 32'h00);
        check("swept dout", 32'(rf0.reg_dout), 32'h00);

        // ---------------- reset mid-sweep ----------------
        rf0.b_addr      = 5'd3;
        rf0.b_data_in   = 8'hA5;
        rf0.b_wr_enable = 1'b1;
        tick();
        rf0.b_wr_enable = 1'b0;
        rf0.clr_req     = 1'b1;
        tick();
        rf0.clr_req     = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid-sweep busy", 32'(rf0.busy), 32'h1);
        resetn = 1'b0;
        #1;
        check("rst mid busy",      32'(rf0.busy),      32'h0);
        check("rst mid gout_dval", 32'(rf0.gout_dval), 32'h0);
        check("rst mid flag",      32'(rf0.reg_flag),  32'h0);
        for (int i = 0; i < 32; i++) begin
            rf0.a_addr = 5'(i);
            #0.1;
            check($sformatf("rst mid r%0d", i), 32'(rf0.a_data_out), 32'h00);
        end
        #1;
        resetn = 1'b1;
        #0.5;
        check("rerel gout_dval pre-edge", 32'(rf0.gout_dval), 32'h0);
        tick();
        check("rerel gout_dval", 32'(rf0.gout_dval), 32'h1);
        check("rerel busy",      32'(rf0.busy),      32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
